// File: rtl/time_set_ctrl.sv
// time_set_ctrl: button-driven time-setting FSM sitting between the debouncers and the clock core.
// Define TIME_SET_SECONDS_EN to add the editable seconds field (SECOND state).
module time_set_ctrl #(
    parameter int REPEAT_DELAY  = 50_000_000,
    parameter int REPEAT_PERIOD = 10_000_000,
    parameter int TIMEOUT       = 0,
    parameter int CNT_W         = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       set,
    input  logic       up,
    input  logic       down,
    input  logic       cancel,
    input  logic       mode24,
    output logic       propagate,
    output logic       isPM,
    output logic [4:0] hours,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic [2:0] currentState
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PM     = 3'd1,
        S_HOUR   = 3'd2,
        S_MINUTE = 3'd3,
        S_SECOND = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] RPT_DLY = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] RPT_PER = CNT_W'(REPEAT_PERIOD);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic             TO_EN   = (TIMEOUT > 0);

    function automatic logic [4:0] hour_step(input logic [4:0] h, input logic inc, input logic m24);
        logic [4:0] r;
        if (m24) begin
            if (inc) r = (h >= 5'd23) ? 5'd0 : h + 5'd1;
            else     r = (h == 5'd0 || h > 5'd23) ? 5'd23 : h - 5'd1;
        end else begin
            if (inc) r = (h >= 5'd12) ? 5'd1 : h + 5'd1;
            else     r = (h <= 5'd1 || h > 5'd12) ? 5'd12 : h - 5'd1;
        end
        return r;
    endfunction

    function automatic logic [5:0] sexa_step(input logic [5:0] v, input logic inc);
        if (inc) return (v >= 6'd59) ? 6'd0 : v + 6'd1;
        return (v == 6'd0 || v > 6'd59) ? 6'd59 : v - 6'd1;
    endfunction

    state_t           state_q, state_d;
    logic             m24_q, m24_d;
    logic             pm_q, pm_d;
    logic [4:0]       hr_q, hr_d;
    logic [5:0]       min_q, min_d;
    logic             snap_pm_q, snap_pm_d;
    logic [4:0]       snap_hr_q, snap_hr_d;
    logic [5:0]       snap_min_q, snap_min_d;
`ifdef TIME_SET_SECONDS_EN
    logic [5:0]       sec_q, sec_d;
    logic [5:0]       snap_sec_q, snap_sec_d;
`endif
    logic             prop_q, prop_d;
    logic             set_prev_q, up_prev_q, down_prev_q, cancel_prev_q;
    logic [CNT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             rpt_on_q, rpt_on_d;
    logic [CNT_W-1:0] to_cnt_q, to_cnt_d;

    logic set_edge, up_edge, down_edge, cancel_edge;
    logic in_edit, dir_up, dir_dn, step, activity, timeout;

    assign set_edge    = set & ~set_prev_q;
    assign up_edge     = up & ~up_prev_q;
    assign down_edge   = down & ~down_prev_q;
    assign cancel_edge = cancel & ~cancel_prev_q;
    assign in_edit     = (state_q != S_IDLE);
    assign dir_up      = up & ~down;
    assign dir_dn      = down & ~up;
    // Holding a button counts as activity so a long auto-repeat never times out.
    assign activity    = set_edge | cancel_edge | up | down;
    assign timeout     = TO_EN && in_edit && !activity && (to_cnt_q == TO_LAST);

    // Auto-repeat: first step on the edge, then after RPT_DLY cycles, then every RPT_PER cycles.
    always_comb begin
        rpt_cnt_d = rpt_cnt_q;
        rpt_on_d  = rpt_on_q;
        step      = 1'b0;
        if (!in_edit || !(dir_up || dir_dn) || cancel_edge || set_edge || timeout) begin
            rpt_cnt_d = '0;
            rpt_on_d  = 1'b0;
        end else if ((dir_up && up_edge) || (dir_dn && down_edge)) begin
            step      = 1'b1;
            rpt_cnt_d = CNT_W'(1);
            rpt_on_d  = 1'b0;
        end else if (rpt_cnt_q == (rpt_on_q ? RPT_PER : RPT_DLY)) begin
            step      = 1'b1;
            rpt_cnt_d = CNT_W'(1);
            rpt_on_d  = 1'b1;
        end else begin
            rpt_cnt_d = rpt_cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d    = state_q;
        m24_d      = m24_q;
        pm_d       = pm_q;
        hr_d       = hr_q;
        min_d      = min_q;
        snap_pm_d  = snap_pm_q;
        snap_hr_d  = snap_hr_q;
        snap_min_d = snap_min_q;
`ifdef TIME_SET_SECONDS_EN
        sec_d      = sec_q;
        snap_sec_d = snap_sec_q;
`endif
        prop_d     = 1'b0;
        to_cnt_d   = to_cnt_q;

        if (!in_edit) begin
            to_cnt_d = '0;
            if (set_edge && !cancel_edge) begin
                m24_d   = mode24;
                pm_d    = mode24 ? 1'b0 : snap_pm_q;
                hr_d    = (!mode24 && snap_hr_q == 5'd0) ? 5'd12 : snap_hr_q;
                min_d   = snap_min_q;
`ifdef TIME_SET_SECONDS_EN
                sec_d   = snap_sec_q;
`endif
                state_d = mode24 ? S_HOUR : S_PM;
            end
        end else if (cancel_edge || timeout) begin
            pm_d     = snap_pm_q;
            hr_d     = snap_hr_q;
            min_d    = snap_min_q;
`ifdef TIME_SET_SECONDS_EN
            sec_d    = snap_sec_q;
`endif
            to_cnt_d = '0;
            state_d  = S_IDLE;
        end else if (set_edge) begin
            to_cnt_d = '0;
            case (state_q)
                S_PM:   state_d = S_HOUR;
                S_HOUR: state_d = S_MINUTE;
`ifdef TIME_SET_SECONDS_EN
                S_MINUTE: state_d = S_SECOND;
                S_SECOND: begin
                    snap_pm_d  = pm_q;
                    snap_hr_d  = hr_q;
                    snap_min_d = min_q;
                    snap_sec_d = sec_q;
                    prop_d     = 1'b1;
                    state_d    = S_IDLE;
                end
`else
                S_MINUTE: begin
                    snap_pm_d  = pm_q;
                    snap_hr_d  = hr_q;
                    snap_min_d = min_q;
                    prop_d     = 1'b1;
                    state_d    = S_IDLE;
                end
`endif
                default: state_d = S_IDLE;
            endcase
        end else begin
            if (step) begin
                case (state_q)
                    S_PM:     pm_d  = ~pm_q;
                    S_HOUR:   hr_d  = hour_step(hr_q, dir_up, m24_q);
                    S_MINUTE: min_d = sexa_step(min_q, dir_up);
`ifdef TIME_SET_SECONDS_EN
                    S_SECOND: sec_d = sexa_step(sec_q, dir_up);
`endif
                    default:  ;
                endcase
            end
            if (activity)   to_cnt_d = '0;
            else if (TO_EN) to_cnt_d = to_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            m24_q         <= 1'b0;
            pm_q          <= 1'b0;
            hr_q          <= '0;
            min_q         <= '0;
            snap_pm_q     <= 1'b0;
            snap_hr_q     <= '0;
            snap_min_q    <= '0;
`ifdef TIME_SET_SECONDS_EN
            sec_q         <= '0;
            snap_sec_q    <= '0;
`endif
            prop_q        <= 1'b0;
            set_prev_q    <= 1'b0;
            up_prev_q     <= 1'b0;
            down_prev_q   <= 1'b0;
            cancel_prev_q <= 1'b0;
            rpt_cnt_q     <= '0;
            rpt_on_q      <= 1'b0;
            to_cnt_q      <= '0;
        end else begin
            state_q       <= state_d;
            m24_q         <= m24_d;
            pm_q          <= pm_d;
            hr_q          <= hr_d;
            min_q         <= min_d;
            snap_pm_q     <= snap_pm_d;
            snap_hr_q     <= snap_hr_d;
            snap_min_q    <= snap_min_d;
`ifdef TIME_SET_SECONDS_EN
            sec_q         <= sec_d;
            snap_sec_q    <= snap_sec_d;
`endif
            prop_q        <= prop_d;
            set_prev_q    <= set;
            up_prev_q     <= up;
            down_prev_q   <= down;
            cancel_prev_q <= cancel;
            rpt_cnt_q     <= rpt_cnt_d;
            rpt_on_q      <= rpt_on_d;
            to_cnt_q      <= to_cnt_d;
        end
    end

    assign propagate    = prop_q;
    assign isPM         = pm_q;
    assign hours        = hr_q;
    assign minutes      = min_q;
`ifdef TIME_SET_SECONDS_EN
    assign seconds      = sec_q;
`else
    assign seconds      = 6'd0;
`endif
    assign currentState = state_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: directed scenarios plus random button sequences against a field-level model.
`timescale 1ns/1ps
module tb_time_set_ctrl;
    localparam int RD = 4;
    localparam int RP = 2;
    localparam int TO = 20;
`ifdef TIME_SET_SECONDS_EN
    localparam bit SEC_EN = 1'b1;
`else
    localparam bit SEC_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset, set, up, down, cancel, mode24;
    logic       propagate, isPM;
    logic [4:0] hours;
    logic [5:0] minutes, seconds;
    logic [2:0] currentState;

    time_set_ctrl #(.REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .TIMEOUT(TO), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .set(set), .up(up), .down(down), .cancel(cancel),
        .mode24(mode24), .propagate(propagate), .isPM(isPM), .hours(hours),
        .minutes(minutes), .seconds(seconds), .currentState(currentState)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0, prop_cnt = 0, exp_prop = 0;
    always @(negedge clk) if (propagate === 1'b1) prop_cnt++;

    // Model: edit state code, working fields, committed snapshot.
    int m_state, m_pm, m_hr, m_min, m_sec, m_m24;
    int s_pm, s_hr, s_min, s_sec;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk($sformatf("%s.state", tag), 32'(currentState), m_state);
        chk($sformatf("%s.isPM", tag), 32'(isPM), m_pm);
        chk($sformatf("%s.hours", tag), 32'(hours), m_hr);
        chk($sformatf("%s.minutes", tag), 32'(minutes), m_min);
        chk($sformatf("%s.seconds", tag), 32'(seconds), m_sec);
        chk($sformatf("%s.pulses", tag), prop_cnt, exp_prop);
    endtask

    task automatic m_reset();
        m_state = 0; m_pm = 0; m_hr = 0; m_min = 0; m_sec = 0; m_m24 = 0;
        s_pm = 0; s_hr = 0; s_min = 0; s_sec = 0;
    endtask

    task automatic m_commit();
        s_pm = m_pm; s_hr = m_hr; s_min = m_min; s_sec = m_sec;
        m_state = 0;
        exp_prop++;
    endtask

    task automatic m_set();
        if (m_state == 0) begin
            m_m24 = int'(mode24);
            m_pm  = m_m24 ? 0 : s_pm;
            m_hr  = (!m_m24 && s_hr == 0) ? 12 : s_hr;
            m_min = s_min;
            m_sec = s_sec;
            m_state = m_m24 ? 2 : 1;
        end else if (m_state == 1) m_state = 2;
        else if (m_state == 2) m_state = 3;
        else if (m_state == 3 && SEC_EN) m_state = 4;
        else m_commit();
    endtask

    task automatic m_cancel();
        if (m_state != 0) begin
            m_pm = s_pm; m_hr = s_hr; m_min = s_min; m_sec = s_sec;
            m_state = 0;
        end
    endtask

    task automatic m_step(input bit inc, input int k);
        for (int j = 0; j < k; j++) begin
            case (m_state)
                1: m_pm = 1 - m_pm;
                2: if (m_m24) m_hr = inc ? (m_hr + 1) % 24 : (m_hr + 23) % 24;
                   else       m_hr = inc ? m_hr % 12 + 1 : (m_hr + 10) % 12 + 1;
                3: m_min = inc ? (m_min + 1) % 60 : (m_min + 59) % 60;
                4: m_sec = inc ? (m_sec + 1) % 60 : (m_sec + 59) % 60;
                default: ;
            endcase
        end
    endtask

    // Steps produced by holding for n clock edges: edge, then RD later, then every RP.
    function automatic int n_steps(input int n);
        if (n <= 0) return 0;
        return 1 + ((n - 1 >= RD) ? 1 + (n - 1 - RD) / RP : 0);
    endfunction

    // which: 0 set, 1 up, 2 down, 3 cancel; held high for n rising edges.
    task automatic hold(input int which, input int n);
        @(negedge clk);
        case (which)
            0: set = 1'b1;
            1: up = 1'b1;
            2: down = 1'b1;
            default: cancel = 1'b1;
        endcase
        repeat (n) @(negedge clk);
        set = 1'b0; up = 1'b0; down = 1'b0; cancel = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_set(input string tag);
        hold(0, 1); m_set(); check_all(tag);
    endtask

    task automatic do_cancel(input string tag);
        hold(3, 1); m_cancel(); check_all(tag);
    endtask

    task automatic do_step(input string tag, input bit inc, input int n);
        hold(inc ? 1 : 2, n); m_step(inc, n_steps(n)); check_all(tag);
    endtask

    initial begin
        reset = 1'b1; set = 1'b0; up = 1'b0; down = 1'b0; cancel = 1'b0; mode24 = 1'b0;
        m_reset();
        repeat (3) @(negedge clk);
        check_all("reset");
        reset = 1'b0;
        @(negedge clk);

        // Full 12h edit to 3:05 PM and commit.
        do_set("t1.enter");
        do_step("t1.pm", 1'b1, 1);
        do_set("t1.tohour");
        for (int i = 0; i < 3; i++) do_step("t1.hr", 1'b1, 1);
        do_set("t1.tomin");
        for (int i = 0; i < 5; i++) do_step("t1.min", 1'b1, 1);
        do_set("t1.commit");
`ifdef TIME_SET_SECONDS_EN
        do_set("t1.commit_sec");
`endif
        chk("t1.isPM", 32'(isPM), 1);
        chk("t1.hours", 32'(hours), 3);
        chk("t1.minutes", 32'(minutes), 5);
        chk("t1.pulse", prop_cnt, 1);

        // Re-enter, edit hours, cancel restores the committed time without a pulse.
        do_set("t4.enter");
        do_set("t4.tohour");
        for (int i = 0; i < 4; i++) do_step("t4.hr", 1'b1, 1);
        do_cancel("t4.cancel");
        chk("t4.hours", 32'(hours), 3);

        // 12h wrap at 12 and 1.
        do_set("t2.enter");
        do_set("t2.tohour");
        for (int i = 0; i < 3; i++) do_step("t2.dn", 1'b0, 1);
        do_step("t2.wrapup", 1'b1, 1);
        do_step("t2.wrapdn", 1'b0, 1);
        do_cancel("t2.cancel");

        // 24h: PM state skipped, wraps at 0 and 23.
        mode24 = 1'b1;
        do_set("t2.enter24");
        chk("t2.skip_pm", 32'(currentState), 2);
        for (int i = 0; i < 4; i++) do_step("t2.dn24", 1'b0, 1);
        do_step("t2.wrap24", 1'b1, 1);
        do_cancel("t2.cancel24");
        mode24 = 1'b0;

        // Auto-repeat on held down from minute 0.
        do_set("t3.enter");
        do_set("t3.tohour");
        do_set("t3.tomin");
        for (int i = 0; i < 5; i++) do_step("t3.dn", 1'b0, 1);
        do_step("t3.hold9", 1'b0, 9);
        chk("t3.minutes", 32'(minutes), 56);
        do_step("t3.holdup", 1'b1, 7);
        do_cancel("t3.cancel");

        // Inactivity timeout.
        do_set("t5.enter");
        repeat (10) @(negedge clk);
        chk("t5.still_edit", 32'(currentState), 1);
        repeat (15) @(negedge clk);
        m_cancel();
        check_all("t5.timeout");

        // up and down together do nothing.
        do_set("t5.enter2");
        do_set("t5.tohour");
        @(negedge clk);
        up = 1'b1; down = 1'b1;
        repeat (6) @(negedge clk);
        up = 1'b0; down = 1'b0;
        @(negedge clk);
        check_all("t5.both");
        do_cancel("t5.cancel");

`ifdef TIME_SET_SECONDS_EN
        // Seconds field edit and commit via SECOND.
        do_set("t6.enter");
        do_set("t6.tohour");
        do_set("t6.tomin");
        do_set("t6.tosec");
        do_step("t6.sdn", 1'b0, 1);
        do_step("t6.swrap", 1'b1, 1);
        do_set("t6.commit");
`endif

        // Async reset in the middle of an edit.
        do_set("ar.enter");
        do_step("ar.pm", 1'b1, 1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        m_reset();
        check_all("ar.reset");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Random button sequences, 12h mode.
        for (int i = 0; i < 250; i++) begin
            int a;
            a = $urandom_range(0, 9);
            case (a)
                0, 1: do_set("rnd.set");
                2, 3: do_step("rnd.up", 1'b1, 1);
                4, 5: do_step("rnd.dn", 1'b0, 1);
                6:    do_step("rnd.holdup", 1'b1, $urandom_range(2, 12));
                7:    do_step("rnd.holddn", 1'b0, $urandom_range(2, 12));
                8:    do_cancel("rnd.cancel");
                default: begin
                    repeat ($urandom_range(1, 4)) @(negedge clk);
                    check_all("rnd.idle");
                end
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
